// File: rtl/mem_wb_writeback_pkg.sv
// Shared types for the MEM/WB writeback stage: load-size encodings, FSM states, defaults.
package mem_wb_writeback_pkg;

    localparam int unsigned DataW = 32;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeRsvd = 2'b11
    } load_size_e;

    typedef enum logic [0:0] {
        StIdle,
        StLoadWait
    } wb_state_e;

    // Reserved size behaves as a word access, including its alignment rule.
    function automatic logic load_aligned(input load_size_e size, input logic [1:0] offset);
        logic ok;
        case (size)
            SizeByte: ok = 1'b1;
            SizeHalf: ok = ~offset[0];
            default:  ok = (offset == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_wb_writeback_load_align.sv
// Selects the addressed byte/half lane of a little-endian read word and zero/sign-extends it.
module mem_wb_writeback_load_align
    import mem_wb_writeback_pkg::*;
#(
    parameter int unsigned DATA_W = DataW
) (
    input  logic [31:0]       rd_word,
    input  logic [1:0]        offset,
    input  load_size_e        size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] data
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_sh   = {offset, 3'b000};
        half_sh   = {offset[1], 4'b0000};
        byte_lane = rd_word[byte_sh +: 8];
        half_lane = rd_word[half_sh +: 16];
        data      = DATA_W'(rd_word);
        case (size)
            SizeByte: data = {{(DATA_W-8){sign_ext & byte_lane[7]}}, byte_lane};
            SizeHalf: data = {{(DATA_W-16){sign_ext & half_lane[15]}}, half_lane};
            default:  data = DATA_W'(rd_word);
        endcase
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB boundary: retires ALU results, performs loads over a req/ack handshake with
// timeout, and drives the register-file write port from registers.
module mem_wb_writeback
    import mem_wb_writeback_pkg::*;
#(
    parameter int unsigned DATA_W  = DataW,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EX_MEM_Valid,
    input  logic              EX_MEM_RegWrite,
    input  logic              EX_MEM_MemToReg,
    input  logic [4:0]        EX_MEM_DstReg,
    input  logic [DATA_W-1:0] EX_MEM_AluResult,
    input  logic [1:0]        EX_MEM_LoadSize,
    input  logic              EX_MEM_LoadSigned,
    output logic              MemReq,
    output logic [31:0]       MemAddr,
    input  logic              MemAck,
    input  logic [31:0]       MemRdData,
    output logic              Stall,
    output logic [4:0]        WB_DstReg,
    output logic [DATA_W-1:0] WB_Data,
    output logic              RegWrite,
    output logic              MisalignErr,
    output logic              BusErr
);

    localparam int unsigned CntW = $clog2(TIMEOUT);

    wb_state_e         state_q;
    logic [CntW-1:0]   cnt_q;
    logic [4:0]        dst_q;
    logic              wr_q;
    load_size_e        size_q;
    logic              sign_q;
    logic [29:0]       word_addr_q;
    logic [1:0]        off_q;

    logic              in_idle;
    logic              in_wait;
    logic              aligned;
    logic              alu_retire;
    logic              load_req;
    logic              misalign;
    logic              timeout_hit;
    logic [DATA_W-1:0] load_data;

    always_comb begin
        in_idle     = (state_q == StIdle);
        in_wait     = (state_q == StLoadWait);
        aligned     = load_aligned(load_size_e'(EX_MEM_LoadSize), EX_MEM_AluResult[1:0]);
        alu_retire  = in_idle && EX_MEM_Valid && !EX_MEM_MemToReg;
        load_req    = in_idle && EX_MEM_Valid && EX_MEM_MemToReg && aligned;
        misalign    = in_idle && EX_MEM_Valid && EX_MEM_MemToReg && !aligned;
        // An ack arriving on the limit cycle takes priority over the abort.
        timeout_hit = in_wait && !MemAck && (cnt_q == CntW'(TIMEOUT - 1));
        MemReq      = load_req || (in_wait && !timeout_hit);
        Stall       = load_req || (in_wait && !MemAck && !timeout_hit);
        MemAddr     = in_wait ? {word_addr_q, 2'b00} : {EX_MEM_AluResult[31:2], 2'b00};
    end

    mem_wb_writeback_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .rd_word  (MemRdData),
        .offset   (off_q),
        .size     (size_q),
        .sign_ext (sign_q),
        .data     (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dst_q       <= '0;
            wr_q        <= 1'b0;
            size_q      <= SizeByte;
            sign_q      <= 1'b0;
            word_addr_q <= '0;
            off_q       <= '0;
            WB_DstReg   <= '0;
            WB_Data     <= '0;
            RegWrite    <= 1'b0;
            MisalignErr <= 1'b0;
            BusErr      <= 1'b0;
        end else begin
            RegWrite    <= 1'b0;
            MisalignErr <= 1'b0;
            BusErr      <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (alu_retire) begin
                        WB_DstReg <= EX_MEM_DstReg;
                        WB_Data   <= EX_MEM_AluResult;
                        RegWrite  <= EX_MEM_RegWrite && (EX_MEM_DstReg != 5'd0);
                    end else if (load_req) begin
                        dst_q       <= EX_MEM_DstReg;
                        wr_q        <= EX_MEM_RegWrite;
                        size_q      <= load_size_e'(EX_MEM_LoadSize);
                        sign_q      <= EX_MEM_LoadSigned;
                        word_addr_q <= EX_MEM_AluResult[31:2];
                        off_q       <= EX_MEM_AluResult[1:0];
                        cnt_q       <= '0;
                        state_q     <= StLoadWait;
                    end else if (misalign) begin
                        MisalignErr <= 1'b1;
                    end
                end
                StLoadWait: begin
                    if (MemAck) begin
                        WB_DstReg <= dst_q;
                        WB_Data   <= load_data;
                        RegWrite  <= wr_q && (dst_q != 5'd0);
                        state_q   <= StIdle;
                    end else if (timeout_hit) begin
                        BusErr  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback with a writeback scoreboard queue.
module tb_mem_wb_writeback;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_MemToReg, EX_MEM_LoadSigned;
    logic [4:0]  EX_MEM_DstReg;
    logic [31:0] EX_MEM_AluResult;
    logic [1:0]  EX_MEM_LoadSize;
    logic        MemReq, MemAck, Stall, RegWrite, MisalignErr, BusErr;
    logic [31:0] MemAddr, MemRdData, WB_Data;
    logic [4:0]  WB_DstReg;

    int  checks = 0;
    int  errors = 0;
    wb_t exp_q[$];

    mem_wb_writeback dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .EX_MEM_Valid      (EX_MEM_Valid),
        .EX_MEM_RegWrite   (EX_MEM_RegWrite),
        .EX_MEM_MemToReg   (EX_MEM_MemToReg),
        .EX_MEM_DstReg     (EX_MEM_DstReg),
        .EX_MEM_AluResult  (EX_MEM_AluResult),
        .EX_MEM_LoadSize   (EX_MEM_LoadSize),
        .EX_MEM_LoadSigned (EX_MEM_LoadSigned),
        .MemReq            (MemReq),
        .MemAddr           (MemAddr),
        .MemAck            (MemAck),
        .MemRdData         (MemRdData),
        .Stall             (Stall),
        .WB_DstReg         (WB_DstReg),
        .WB_Data           (WB_Data),
        .RegWrite          (RegWrite),
        .MisalignErr       (MisalignErr),
        .BusErr            (BusErr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mtr, input logic rw, input logic [4:0] dst,
                         input logic [31:0] alu, input logic [1:0] size, input logic sgn);
        EX_MEM_Valid      = 1'b1;
        EX_MEM_MemToReg   = mtr;
        EX_MEM_RegWrite   = rw;
        EX_MEM_DstReg     = dst;
        EX_MEM_AluResult  = alu;
        EX_MEM_LoadSize   = size;
        EX_MEM_LoadSigned = sgn;
    endtask

    task automatic wb_check(input string tag);
        wb_t e;
        chk({tag, "_regwrite"}, {31'd0, RegWrite}, 32'd1);
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_queue: observed empty scoreboard expected an entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_dst"}, {27'd0, WB_DstReg}, {27'd0, e.dst});
            chk({tag, "_data"}, WB_Data, e.data);
        end
    endtask

    // Presents a load, acks it in cycle ack_at (cycle 0 = request cycle), and returns
    // with the EX_MEM bus idle, one cycle after the ack edge.
    task automatic do_load(input string tag, input logic [4:0] dst, input logic [31:0] addr,
                           input logic [1:0] size, input logic sgn, input logic [31:0] rd,
                           input int ack_at);
        int stalls = 0;
        int reqs   = 0;
        drive(1'b1, 1'b1, dst, addr, size, sgn);
        for (int i = 0; i <= ack_at; i++) begin
            if (i == ack_at) begin
                MemAck    = 1'b1;
                MemRdData = rd;
            end
            #1;
            if (Stall) stalls++;
            if (MemReq) reqs++;
            if (i == 0 || i == ack_at)
                chk({tag, "_memaddr"}, MemAddr, {addr[31:2], 2'b00});
            step();
        end
        MemAck       = 1'b0;
        MemRdData    = 32'h5A5A_5A5A;
        EX_MEM_Valid = 1'b0;
        chk({tag, "_stall_cycles"}, stalls, ack_at);
        chk({tag, "_req_cycles"}, reqs, ack_at + 1);
    endtask

    initial begin
        int  reqs;
        bit  released;

        rst_n = 1'b0;
        EX_MEM_Valid = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 2'b00, 1'b0);
        EX_MEM_Valid = 1'b0;
        MemAck = 1'b0;
        MemRdData = 32'd0;
        step();
        step();
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_wb_dst", {27'd0, WB_DstReg}, 32'd0);
        chk("rst_wb_data", WB_Data, 32'd0);
        chk("rst_errs", {30'd0, MisalignErr, BusErr}, 32'd0);
        chk("rst_req_stall", {30'd0, MemReq, Stall}, 32'd0);
        rst_n = 1'b1;
        step();

        // Non-load retire, then back-to-back non-loads.
        drive(1'b0, 1'b1, 5'd5, 32'h0000_1234, 2'b00, 1'b0);
        exp_q.push_back('{dst: 5'd5, data: 32'h0000_1234});
        #1;
        chk("alu_stall", {31'd0, Stall}, 32'd0);
        step();
        drive(1'b0, 1'b1, 5'd9, 32'hA5A5_0001, 2'b00, 1'b0);
        exp_q.push_back('{dst: 5'd9, data: 32'hA5A5_0001});
        wb_check("alu5");
        step();
        drive(1'b0, 1'b1, 5'd10, 32'h0BAD_F00D, 2'b00, 1'b0);
        exp_q.push_back('{dst: 5'd10, data: 32'h0BAD_F00D});
        wb_check("b2b_9");
        step();
        EX_MEM_Valid = 1'b0;
        wb_check("b2b_10");
        step();
        chk("idle_regwrite", {31'd0, RegWrite}, 32'd0);

        // Non-load to r0 never writes.
        drive(1'b0, 1'b1, 5'd0, 32'h1111_2222, 2'b00, 1'b0);
        step();
        EX_MEM_Valid = 1'b0;
        chk("r0_alu_regwrite", {31'd0, RegWrite}, 32'd0);

        // Loads: signed/unsigned byte, signed half with immediate ack, reserved size.
        exp_q.push_back('{dst: 5'd3, data: 32'hFFFF_FF80});
        do_load("lb", 5'd3, 32'h0000_1001, 2'b00, 1'b1, 32'h0000_8000, 3);
        wb_check("lb");
        exp_q.push_back('{dst: 5'd4, data: 32'h0000_0080});
        do_load("lbu", 5'd4, 32'h0000_1001, 2'b00, 1'b0, 32'h0000_8000, 3);
        wb_check("lbu");
        exp_q.push_back('{dst: 5'd12, data: 32'hFFFF_8001});
        do_load("lh", 5'd12, 32'h0000_2002, 2'b01, 1'b1, 32'h8001_0000, 1);
        wb_check("lh");
        exp_q.push_back('{dst: 5'd13, data: 32'hDEAD_BEEF});
        do_load("lrsvd", 5'd13, 32'h0000_6000, 2'b11, 1'b1, 32'hDEAD_BEEF, 2);
        wb_check("lrsvd");

        // Misaligned half.
        drive(1'b1, 1'b1, 5'd14, 32'h0000_2003, 2'b01, 1'b1);
        #1;
        chk("mis_req_stall", {30'd0, MemReq, Stall}, 32'd0);
        step();
        EX_MEM_Valid = 1'b0;
        chk("mis_pulse", {31'd0, MisalignErr}, 32'd1);
        chk("mis_regwrite", {31'd0, RegWrite}, 32'd0);
        step();
        chk("mis_pulse_end", {31'd0, MisalignErr}, 32'd0);

        // Word load that never gets an ack.
        drive(1'b1, 1'b1, 5'd6, 32'h0000_4000, 2'b10, 1'b0);
        reqs = 0;
        released = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (MemReq) reqs++;
            if (!Stall) begin
                released = 1'b1;
                step();
                break;
            end
            step();
        end
        EX_MEM_Valid = 1'b0;
        chk("to_released", {31'd0, released}, 32'd1);
        chk("to_req_cycles", reqs, 32'd16);
        chk("to_buserr", {31'd0, BusErr}, 32'd1);
        chk("to_regwrite", {31'd0, RegWrite}, 32'd0);
        step();
        chk("to_buserr_end", {31'd0, BusErr}, 32'd0);

        // Load to r0, then a normal non-load.
        do_load("lr0", 5'd0, 32'h0000_7004, 2'b10, 1'b0, 32'h1234_5678, 2);
        chk("lr0_regwrite", {31'd0, RegWrite}, 32'd0);
        drive(1'b0, 1'b1, 5'd7, 32'h0000_0777, 2'b00, 1'b0);
        exp_q.push_back('{dst: 5'd7, data: 32'h0000_0777});
        step();
        EX_MEM_Valid = 1'b0;
        wb_check("alu7");

        // Reset while a load is outstanding.
        drive(1'b1, 1'b1, 5'd8, 32'h0000_5000, 2'b10, 1'b0);
        step();
        step();
        chk("rstld_req_before", {30'd0, MemReq, Stall}, 32'd3);
        rst_n = 1'b0;
        EX_MEM_Valid = 1'b0;
        #1;
        chk("rstld_req_stall", {30'd0, MemReq, Stall}, 32'd0);
        chk("rstld_regwrite", {31'd0, RegWrite}, 32'd0);
        step();
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 5'd11, 32'h0000_CAFE, 2'b00, 1'b0);
        exp_q.push_back('{dst: 5'd11, data: 32'h0000_CAFE});
        step();
        EX_MEM_Valid = 1'b0;
        wb_check("post_rst");
        step();
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_writeback.md
# mem_wb_writeback

Writeback-side producer for the register file: owns the MEM/WB boundary of the pipeline. Accepts retiring instructions from the EX/MEM latch, performs load accesses to data memory over a req/ack handshake with variable latency, aligns and extends load data, and drives the register-file write port (WB_DstReg, WB_Data, RegWrite) from registers. Stalls the upstream pipeline while a load is outstanding.

## Interface
- DATA_W, 32, datapath width
- TIMEOUT, 16, max cycles waiting for MemAck before abort (≥2)
- clk  in  1  pipeline clock; all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- EX_MEM_Valid  in  1  instruction present on EX_MEM_* this cycle
- EX_MEM_RegWrite  in  1  instruction writes a register
- EX_MEM_MemToReg  in  1  instruction is a load
- EX_MEM_DstReg  in  5  destination register
- EX_MEM_AluResult  in  DATA_W  ALU result / load address
- EX_MEM_LoadSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- EX_MEM_LoadSigned  in  1  sign-extend byte/half loads
- MemReq  out  1  load request, held until ack
- MemAddr  out  32  word-aligned address ({addr[31:2],2'b00})
- MemAck  in  1  read data valid this cycle
- MemRdData  in  32  read word, little-endian lanes
- Stall  out  1  combinational; upstream holds EX_MEM_* while high
- WB_DstReg  out  5  registered write address
- WB_Data  out  DATA_W  registered write data
- RegWrite  out  1  registered one-cycle write strobe
- MisalignErr  out  1  registered one-cycle pulse
- BusErr  out  1  registered one-cycle pulse (timeout)

## Operation
- FSM states: IDLE, LOAD_WAIT.
- IDLE, Valid & !MemToReg: next posedge WB_DstReg←DstReg, WB_Data←AluResult, RegWrite←EX_MEM_RegWrite & (DstReg≠0). Stall=0.
- IDLE, Valid & MemToReg & aligned: MemReq=1 combinationally, Stall=1; posedge captures DstReg, RegWrite, size, signed, addr[1:0]; →LOAD_WAIT; timeout counter←0.
- Alignment: half needs addr[0]=0, word/reserved needs addr[1:0]=0, byte always aligned. Misaligned load: no MemReq, no write, MisalignErr pulse next cycle, Stall=0, stays IDLE.
- LOAD_WAIT: MemReq=1, MemAddr held from captured address; Stall=!MemAck. EX_MEM_* ignored.
- On MemAck: select lane — byte = MemRdData[8*a+7:8*a], half = MemRdData[16*a[1]+15:16*a[1]]; zero- or sign-extend to DATA_W; register to WB outputs with captured RegWrite & (DstReg≠0); →IDLE.
- Counter increments each LOAD_WAIT cycle without ack; reaching TIMEOUT-1 without ack: MemReq drops, no write, BusErr pulse, Stall=0 that cycle, →IDLE. Ack on the same cycle as the limit wins (normal write).
- DstReg=0 never produces RegWrite=1.
- RegWrite, MisalignErr, BusErr are 0 in any cycle not following a retirement/error event; WB_DstReg/WB_Data hold last value otherwise.

## Timing
- Reset (async assert, sync deassert handled at top): state IDLE, RegWrite=0, MisalignErr=0, BusErr=0, WB_DstReg=0, WB_Data=0, counter=0; MemReq/Stall evaluate to 0 with Valid low. Reset during LOAD_WAIT abandons the load silently.
- Non-load latency: 1 cycle (accept at edge N, RegWrite high cycle N+1).
- Load latency: request cycle + wait cycles + 1; ack in first LOAD_WAIT cycle → RegWrite 2 cycles after acceptance.
- Upstream advances on the edge where Stall=0; ack/timeout cycle deasserts Stall so the next instruction is presented the following cycle, never re-accepting the load.
- Outputs are stable for a full cycle so the register file captures them on the posedge after assertion; back-to-back non-loads give RegWrite high on consecutive cycles.

## Structure
- Shared package: load-size encodings, FSM state enum, DATA_W default.
- One sub-module: load_align (combinational lane select + extend, inputs word/offset/size/signed).

## Test plan
- Reset, then non-load DstReg=5, AluResult=0x0000_1234, RegWrite=1 → next cycle RegWrite=1, WB_DstReg=5, WB_Data=0x1234, Stall never high.
- Signed byte load addr 0x1001, MemRdData=0x0000_8000, ack after 3 cycles → MemAddr=0x1000, Stall high 3 cycles, WB_Data=0xFFFF_FF80; unsigned variant → 0x0000_0080.
- Half load addr 0x2003 → MemReq never asserted, MisalignErr one pulse, RegWrite=0.
- Word load, TIMEOUT=16, no ack → MemReq high 16 cycles, BusErr pulse, no RegWrite, Stall drops.
- Load with DstReg=0, ack → RegWrite stays 0; next non-load to reg 7 retires normally.
- rst_n low mid LOAD_WAIT → MemReq, Stall, RegWrite all 0 immediately; after release a non-load retires in 1 cycle.
